// File: rtl/periph_rr_arbiter.sv
`default_nettype none
// ============================================================================
// periph_rr_arbiter : round-robin req/gnt arbiter sharing one register-bus
// target, with in-order response routing via a winner-index FIFO.
// Optional feature macro: PERIPH_ARB_LOCK_EN (adds lock_i bus locking).
// Rev 1.0
// ============================================================================
module periph_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 10,
  parameter int MAX_OUTST = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_i,
  output logic [N_REQ-1:0]      gnt_o,
  input  logic [N_REQ*32-1:0]   add_i,
  input  logic [N_REQ-1:0]      wen_i,
  input  logic [N_REQ*4-1:0]    be_i,
  input  logic [N_REQ*32-1:0]   data_i,
  input  logic [N_REQ*ID_W-1:0] id_i,
`ifdef PERIPH_ARB_LOCK_EN
  input  logic [N_REQ-1:0]      lock_i,
`endif
  output logic [31:0]           r_data_o,
  output logic [N_REQ-1:0]      r_valid_o,
  output logic [ID_W-1:0]       r_id_o,
  output logic                  tgt_req_o,
  input  logic                  tgt_gnt_i,
  output logic [31:0]           tgt_add_o,
  output logic                  tgt_wen_o,
  output logic [3:0]            tgt_be_o,
  output logic [31:0]           tgt_data_o,
  output logic [ID_W-1:0]       tgt_id_o,
  input  logic [31:0]           tgt_r_data_i,
  input  logic                  tgt_r_valid_i,
  input  logic [ID_W-1:0]       tgt_r_id_i,
  output logic                  err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FP_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTST];
  logic [FP_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [31:0]      add_a  [N_REQ];
  logic [31:0]      data_a [N_REQ];
  logic [3:0]       be_a   [N_REQ];
  logic [ID_W-1:0]  id_a   [N_REQ];

  logic             full, empty;
  logic             arb_vld;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] arb_probe;
  int               arb_j;
  logic             cand_vld;
  logic [IDX_W-1:0] cand_idx;
  logic             lock_act;
  logic [IDX_W-1:0] winner;
  logic             req_int;
  logic             hs;
  logic             pop;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign add_a[g]  = add_i[g*32 +: 32];
    assign data_a[g] = data_i[g*32 +: 32];
    assign be_a[g]   = be_i[g*4 +: 4];
    assign id_a[g]   = id_i[g*ID_W +: ID_W];
  end

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  // Scan from the highest offset down so the closest requester at/after rr_ptr wins.
  always_comb begin
    arb_vld   = 1'b0;
    arb_idx   = '0;
    arb_j     = 0;
    arb_probe = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      arb_j = int'(rr_ptr_q) + k;
      if (arb_j >= N_REQ) arb_j = arb_j - N_REQ;
      arb_probe = IDX_W'(arb_j);
      if (req_i[arb_probe]) begin
        arb_vld = 1'b1;
        arb_idx = arb_probe;
      end
    end
  end

`ifdef PERIPH_ARB_LOCK_EN
  logic [IDX_W-1:0] last_q;
  logic             last_vld_q;

  assign lock_act = last_vld_q & lock_i[last_q];
  assign cand_vld = lock_act ? req_i[last_q] : arb_vld;
  assign cand_idx = lock_act ? last_q : arb_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (hs) begin
      last_q     <= winner;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign lock_act = 1'b0;
  assign cand_vld = arb_vld;
  assign cand_idx = arb_idx;
`endif

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_vld && !full && !tgt_gnt_i) begin
          state_d = ST_HOLD;
          win_d   = cand_idx;
        end
      end
      ST_HOLD: begin
        if (tgt_gnt_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs; reset gates the combinational paths so outputs drop immediately.
  always_comb begin
    winner  = win_q;
    req_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        winner  = cand_idx;
        req_int = cand_vld & ~full;
      end
      ST_HOLD: begin
        winner  = win_q;
        req_int = 1'b1;
      end
      default: begin
        winner  = win_q;
        req_int = 1'b0;
      end
    endcase
    tgt_req_o      = req_int & ~rst_i;
    gnt_o          = '0;
    gnt_o[winner]  = req_int & tgt_gnt_i & ~rst_i;
  end

  assign hs = tgt_req_o & tgt_gnt_i;

  assign tgt_add_o  = rst_i ? 32'h0 : add_a[winner];
  assign tgt_wen_o  = rst_i ? 1'b0 : wen_i[winner];
  assign tgt_be_o   = rst_i ? 4'h0 : be_a[winner];
  assign tgt_data_o = rst_i ? 32'h0 : data_a[winner];
  assign tgt_id_o   = rst_i ? '0 : id_a[winner];

  assign pop = tgt_r_valid_i & ~empty;

  always_comb begin
    r_valid_o               = '0;
    r_valid_o[fifo_q[rd_q]] = pop & ~rst_i;
  end

  assign r_data_o = rst_i ? 32'h0 : tgt_r_data_i;
  assign r_id_o   = rst_i ? '0 : tgt_r_id_i;
  assign err_o    = err_q;

  // While a lock is held the pointer is frozen so the rotation resumes where it paused.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (tgt_r_valid_i & empty);
    if (hs && !lock_act) begin
      rr_ptr_d = (winner == IDX_LAST) ? '0 : winner + IDX_W'(1);
    end
    if (hs)  wr_d = (wr_q == FP_LAST) ? '0 : wr_q + FP_W'(1);
    if (pop) rd_d = (rd_q == FP_LAST) ? '0 : rd_q + FP_W'(1);
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (hs) fifo_q[wr_q] <= winner;
    end
  end

endmodule
`default_nettype wire
